// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I/RV32E core: FSM states,
// opcode/funct encodings, ALU operations and the ALU function itself.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic alu_op_e alu_decode(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(alu_op_e op, logic [XLEN-1:0] x,
                                               logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (op)
      ALU_SUB:  r = x - y;
      ALU_SLL:  r = x << y[4:0];
      ALU_SLT:  r = {31'b0, $signed(x) < $signed(y)};
      ALU_SLTU: r = {31'b0, x < y};
      ALU_XOR:  r = x ^ y;
      ALU_SRL:  r = x >> y[4:0];
      ALU_SRA:  r = $signed(x) >>> y[4:0];
      ALU_OR:   r = x | y;
      ALU_AND:  r = x & y;
      default:  r = x + y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: NUM_REGS x 32, two async read ports, one
// synchronous write port; x0 always reads as zero and is never written.
module mc_regfile
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multi_cycle_processor.sv
// Multi-cycle RV32I/RV32E-subset core on a single req/ready memory port.
// Define INSTRET_COUNTER_EN to add the retired-instruction counter output.
module multi_cycle_processor
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halt,
  output logic        illegal
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam int  AW    = (NUM_REGS == 16) ? 4 : 5;
  localparam bit  RV32E = (NUM_REGS == 16);

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]     imm_q, imm_d, aluout_q, aluout_d, mdr_q, mdr_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [31:0]     imm_sel;
  logic            legal, is_sys, use_rd, use_rs1, use_rs2, bad_idx;
  logic            is_store, is_jal, taken;
  alu_op_e         alu_op;
  logic            rf_we;
  logic [31:0]     rf_rdata1, rf_rdata2, rf_wdata;

  assign opcode   = ir_q[6:0];
  assign rd       = ir_q[11:7];
  assign f3       = ir_q[14:12];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign f7       = ir_q[31:25];
  assign is_store = (opcode == OP_STORE);
  assign is_jal   = (opcode == OP_JAL);
  assign taken    = (a_q == b_q) ^ f3[0];

  always_comb begin
    legal   = 1'b0;
    is_sys  = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_sel = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_R: begin
        legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
        use_rd  = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_I: begin
        // shift-immediates reuse funct7 as the shift kind; only two encodings exist
        legal  = (f3 == F3_SLL) ? (f7 == F7_BASE) :
                 (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        legal  = (f3 == F3_W);
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE: begin
        legal   = (f3 == F3_W);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_sel = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OP_BRANCH: begin
        legal   = (f3 == F3_BEQ || f3 == F3_BNE);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_sel = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      OP_JAL: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        imm_sel = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        is_sys = (ir_q == INSN_ECALL || ir_q == INSN_EBREAK);
        legal  = is_sys;
      end
      default: legal = 1'b0;
    endcase
    bad_idx = RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]));
  end

  always_comb begin
    if (opcode == OP_R || opcode == OP_I)
      alu_op = alu_decode(f3, ir_q[30] && (opcode == OP_R || f3 == F3_SR));
    else
      alu_op = ALU_ADD;
  end

  always_comb begin
    case (opcode)
      OP_LOAD: rf_wdata = mdr_q;
      OP_JAL:  rf_wdata = pc_q + 32'd4;
      default: rf_wdata = aluout_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_rdata1;
        b_d   = rf_rdata2;
        imm_d = imm_sel;
        if (!legal || bad_idx) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else if (is_sys) begin
          state_d   = S_TRAP;
        end else begin
          state_d   = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        aluout_d = alu_exec(alu_op, a_q, (opcode == OP_R) ? b_q : imm_q);
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_d    = taken ? pc_q + imm_q : pc_q + 32'd4;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_store) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = is_jal ? pc_q + imm_q : pc_q + 32'd4;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

  // reset gates the request combinationally so an in-flight transfer dies at once
  assign mem_req   = (state_q == S_FETCH || state_q == S_MEM) && !reset;
  assign mem_we    = (state_q == S_MEM) && is_store;
  assign mem_addr  = (state_q == S_MEM) ? {aluout_q[31:2], 2'b00} : {pc_q[31:2], 2'b00};
  assign mem_wdata = b_q;
  assign halt      = (state_q == S_TRAP);
  assign illegal   = illegal_q;

  mc_regfile #(.NUM_REGS(NUM_REGS), .AW(AW)) u_rf (
    .clock  (clock),
    .reset  (reset),
    .raddr1 (rs1[AW-1:0]),
    .raddr2 (rs2[AW-1:0]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rd[AW-1:0]),
    .wdata  (rf_wdata)
  );

`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret_q, instret_d;
  logic        retire;

  assign retire = (state_q == S_WB) ||
                  (state_q == S_EXECUTE && opcode == OP_BRANCH) ||
                  (state_q == S_MEM && is_store && mem_ready);

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multi_cycle_processor.sv
// Directed bench for multi_cycle_processor (RV32E build): runs a small program
// through a wait-state memory model and checks architectural state at fixed cycles.
module tb_multi_cycle_processor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready = 1'b0, halt, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
`ifdef INSTRET_COUNTER_EN
  logic [31:0] instret;
`endif

  logic [31:0] mem [64];
  int          wait_n = 0;
  int          wcnt = 0;
  int          unstable = 0;
  bit          in_txn = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  int          vectors = 0;
  int          miscompares = 0;

  multi_cycle_processor #(.RESET_PC(32'h0), .NUM_REGS(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halt      (halt),
    .illegal   (illegal)
`ifdef INSTRET_COUNTER_EN
    ,
    .instret   (instret)
`endif
  );

  always #5 clock = ~clock;

  // memory model: answers after wait_n waiting cycles, tracks request stability
  always @(negedge clock) begin
    if (reset || !mem_req) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      in_txn    = 1'b0;
    end else begin
      if (in_txn && (mem_addr !== s_addr || mem_we !== s_we ||
                     (mem_we && mem_wdata !== s_wdata)))
        unstable++;
      s_addr  = mem_addr;
      s_we    = mem_we;
      s_wdata = mem_wdata;
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        wcnt      = 0;
        in_txn    = 1'b0;
        mem_rdata = mem[mem_addr[7:2]];
        if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
        in_txn    = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 200 && !halt; i++) cycles(1);
  endtask

  initial begin
    int reqs;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_007F;
    mem[0]  = 32'h0050_0093; // addi x1,x0,5
    mem[1]  = 32'h0070_0113; // addi x2,x0,7
    mem[2]  = 32'h0020_81B3; // add  x3,x1,x2
    mem[3]  = 32'h0430_2023; // sw   x3,0x40(x0)
    mem[4]  = 32'h0400_2203; // lw   x4,0x40(x0)
    mem[5]  = 32'h0020_9463; // bne  x1,x2,+8   -> 0x1C
    mem[6]  = 32'h0080_006F; // jal  x0,+8      -> 0x20
    mem[7]  = 32'hFE10_8EE3; // beq  x1,x1,-4   -> 0x18
    mem[8]  = 32'h0100_02EF; // jal  x5,+16     -> 0x30
    mem[12] = 32'h0090_0013; // addi x0,x0,9
    mem[13] = 32'h0000_007F; // illegal opcode
    mem[16] = 32'h0;

    cycles(2);
    check("reset_req",     {31'b0, mem_req}, 32'd0);
    check("reset_halt",    {31'b0, halt},    32'd0);
    check("reset_illegal", {31'b0, illegal}, 32'd0);
    check("reset_pc",      dut.pc_q,         32'h0);
    reset = 1'b0;

    cycles(12);
    check("alu_x3", dut.u_rf.regs_q[3], 32'd12);
    check("alu_pc", dut.pc_q,           32'h0C);
    wait_n = 3;
    cycles(10);
    check("sw_mem", mem[16],  32'd12);
    check("sw_pc",  dut.pc_q, 32'h10);
    cycles(11);
    check("lw_x4",  dut.u_rf.regs_q[4], 32'd12);
    check("lw_pc",  dut.pc_q,           32'h14);
    check("addr_stable", unstable, 32'd0);
    wait_n = 0;

    cycles(3);
    check("bne_pc",   dut.pc_q,           32'h1C);
    check("bne_no_rd", dut.u_rf.regs_q[8], 32'h0);
    cycles(3);
    check("beq_pc",   dut.pc_q,           32'h18);
    cycles(4);
    check("j_pc",     dut.pc_q,           32'h20);
    cycles(4);
    check("jal_pc",   dut.pc_q,           32'h30);
    check("jal_x5",   dut.u_rf.regs_q[5], 32'h24);
    cycles(4);
    check("x0_zero",  dut.u_rf.regs_q[0], 32'h0);
    check("x0_pc",    dut.pc_q,           32'h34);
`ifdef INSTRET_COUNTER_EN
    check("instret_10", instret, 32'd10);
`endif
    cycles(2);
    check("ill_halt",    {31'b0, halt},    32'd1);
    check("ill_illegal", {31'b0, illegal}, 32'd1);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (mem_req) reqs++;
    end
    check("trap_no_req", reqs, 32'd0);
`ifdef INSTRET_COUNTER_EN
    check("instret_frozen", instret, 32'd10);
`endif

    mem[13] = 32'h0020_8A33; // add x20,x1,x2 (x20 does not exist in RV32E)
    restart();
    check("restart_clear", dut.u_rf.regs_q[3], 32'h0);
    run_to_halt();
    check("rv32e_halt",    {31'b0, halt},    32'd1);
    check("rv32e_illegal", {31'b0, illegal}, 32'd1);
    check("rv32e_pc",      dut.pc_q,         32'h34);

    mem[13] = 32'h0000_0073; // ecall
    restart();
    run_to_halt();
    check("ecall_halt",    {31'b0, halt},    32'd1);
    check("ecall_illegal", {31'b0, illegal}, 32'd0);
    check("ecall_x5",      dut.u_rf.regs_q[5], 32'h24);

    wait_n = 5;
    restart();
    cycles(3);
    check("midfetch_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("midfetch_drop", {31'b0, mem_req}, 32'd0);
    check("midfetch_pc",   dut.pc_q,         32'h0);
`ifdef INSTRET_COUNTER_EN
    check("midfetch_instret", instret, 32'd0);
`endif
    wait_n = 0;
    cycles(1);
    reset = 1'b0;
    #1;
    check("refetch_req",  {31'b0, mem_req}, 32'd1);
    check("refetch_addr", mem_addr,         32'h0);
    cycles(4);
    check("refetch_x1",   dut.u_rf.regs_q[1], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_cycle_processor.md
# multi_cycle_processor

Multi-cycle RV32I-subset core: one FSM walks each instruction through fetch, decode, execute, memory and writeback over a single shared memory port with a req/ready handshake. It succeeds the single-cycle datapath and adds loads, stores, branches, JAL, wait-state tolerance, a configurable reset vector and register count (RV32E option), and a sticky trap/halt. It sits at the top of the processor hierarchy; the memory and testbench model attach to its memory port.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NUM_REGS, 32, architectural registers (32 = RV32I, 16 = RV32E); only 16 or 32 legal
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- mem_req  output  1  memory request, held until mem_ready
- mem_we  output  1  1 = store, 0 = read (fetch/load)
- mem_addr  output  32  word-aligned byte address
- mem_wdata  output  32  store data
- mem_rdata  input  32  read data, sampled when mem_req && mem_ready
- mem_ready  input  1  transaction completes this cycle
- halt  output  1  sticky: ECALL/EBREAK retired or illegal instruction
- illegal  output  1  sticky: trap caused by illegal instruction

## Operation
- Supported: R-type ALU (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND), I-type ALU, LW, SW, BEQ, BNE, JAL, ECALL/EBREAK; anything else, or any rs1/rs2/rd index >= NUM_REGS, is illegal
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP
- FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready latch ir <- mem_rdata, go to DECODE; otherwise stay
- DECODE: latch A <- x[rs1], B <- x[rs2], imm; illegal -> TRAP with illegal=1; ECALL/EBREAK -> TRAP with illegal=0
- EXECUTE: aluout <- A op (B or imm); load/store -> MEM; R/I/JAL -> WB; BEQ/BNE -> pc <- taken ? pc+imm : pc+4, then FETCH
- MEM: mem_req=1, mem_addr=aluout, mem_we=store, mem_wdata=B; on mem_ready: load latches mdr, goes to WB; store sets pc <- pc+4, goes to FETCH
- WB: x[rd] <- aluout / mdr / pc+4 (JAL); writes to x0 discarded; pc <- JAL ? pc+imm : pc+4; go to FETCH
- TRAP: no requests; halt=1; remain until reset
- Arithmetic is 32-bit modulo; shift amount = low 5 bits; low 2 address bits ignored (word access only)
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state and latched registers only, with no path from mem_ready

## Timing
- Reset: state=FETCH, pc=RESET_PC, all registers 0, ir/A/B/aluout/mdr 0, halt=0, illegal=0; mem_req=0 while reset is asserted; first request in the first cycle after deassertion
- Zero-wait memory: ALU and JAL take 4 cycles, LW 5, SW 4, branch 3, ECALL 2 to halt; each wait cycle adds 1
- Handshake: address, we and wdata are stable while mem_req=1; mem_ready while mem_req=0 is ignored; exactly one transfer per FETCH/MEM visit
- Register write occurs on the clock edge leaving WB; a read of the same register in a later DECODE sees the new value
- Reset mid-transaction drops mem_req asynchronously; the partial transaction is abandoned

## Configuration
- INSTRET_COUNTER_EN defined: adds output instret[31:0], reset 0, incremented on every retirement (leaving WB, store MEM, or branch EXECUTE), wraps 32'hFFFF_FFFF -> 0, frozen in TRAP
- Undefined: no port, no counter logic

## Structure
- core_pkg: state enum, opcode/funct3/funct7 constants, alu_op enum, XLEN=32
- One sub-module, mc_regfile: NUM_REGS x 32 registers, 2 asynchronous read ports, 1 synchronous write port, x0 hard-wired to 0, asynchronous reset

## Test plan
- addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 with zero-wait memory -> x3=12 after 12 cycles; pc=0x0C
- sw x3,0x40(x0) then lw x4,0x40(x0), with 3 wait cycles on each transfer -> memory[0x40]=12, x4=12, mem_addr stable during waits
- bne x1,x2,+8 taken and beq x1,x1,-4 -> pc follows targets; branch takes 3 cycles; no write to rd
- jal x5,+16 at pc 0x20 -> x5=0x24, pc=0x30; addi x0,x0,9 -> x0 stays 0
- opcode 0x7F, then (NUM_REGS=16) add x20,x1,x2, then ecall -> halt=1 with illegal=1/1/0; no further mem_req
- reset asserted mid-FETCH with mem_ready low -> mem_req drops same cycle; refetch at RESET_PC; instret=0 when INSTRET_COUNTER_EN is defined
